// File: rtl/t03_layer_fetch_sched.sv
// Horizontal-blank fetch scheduler for the P1/P2/TEXT line buffers.
// One memory read outstanding at a time; the ping-pong bank flips only when a whole line has been fetched.
module t03_layer_fetch_sched #(
  parameter int HBLANK_START = 600,
  parameter int DEADLINE     = 790,
  parameter int V_FIRST      = 29,
  parameter int V_LAST       = 798,
  parameter int WORDS        = 4,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [10:0]       Hcnt,
  input  logic [10:0]       Vcnt,
  input  logic [2:0]        layer_en,
  input  logic [ADDR_W-1:0] p1_base,
  input  logic [ADDR_W-1:0] p2_base,
  input  logic [ADDR_W-1:0] txt_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              lb_we,
  output logic [1:0]        lb_layer,
  output logic [3:0]        lb_idx,
  output logic [31:0]       lb_data,
  output logic              lb_bank,
  output logic              line_ready,
  output logic              underrun,
  input  logic              underrun_clr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [10:0] H_TRIG    = 11'(HBLANK_START);
  localparam logic [10:0] H_DEAD    = 11'(DEADLINE);
  localparam logic [10:0] V_LO      = 11'(V_FIRST);
  localparam logic [10:0] V_HI      = 11'(V_LAST);
  localparam logic [3:0]  LAST_WORD = 4'(WORDS - 1);

  state_t            state_q, state_d;
  logic [2:0]        en_q, en_d;
  logic [ADDR_W-1:0] p1_q, p1_d, p2_q, p2_d, txt_q, txt_d;
  logic [1:0]        layer_q, layer_d;
  logic [3:0]        word_q, word_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              lb_we_q, lb_we_d;
  logic [1:0]        lb_layer_q, lb_layer_d;
  logic [3:0]        lb_idx_q, lb_idx_d;
  logic [31:0]       lb_data_q, lb_data_d;
  logic              lb_bank_q, lb_bank_d;
  logic              line_ready_q, line_ready_d;
  logic              underrun_q, underrun_d;

  logic              trigger_s, deadline_s, wr_s, miss_s;
  logic [2:0]        first_s, next_s;
  logic [ADDR_W-1:0] base_sel_s;

  // Lowest enabled layer at or above 'from'; bit 2 flags that one exists.
  function automatic logic [2:0] pick_layer(input logic [2:0] en, input logic [1:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (en[i] && (2'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign trigger_s  = (state_q == S_IDLE) && (Hcnt == H_TRIG) && (Vcnt >= V_LO) && (Vcnt <= V_HI);
  assign deadline_s = (Hcnt == H_DEAD);
  assign first_s    = pick_layer(layer_en, 2'd0);
  assign next_s     = pick_layer(en_q, layer_q + 2'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      en_q         <= 3'b000;
      p1_q         <= {ADDR_W{1'b0}};
      p2_q         <= {ADDR_W{1'b0}};
      txt_q        <= {ADDR_W{1'b0}};
      layer_q      <= 2'd0;
      word_q       <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      lb_we_q      <= 1'b0;
      lb_layer_q   <= 2'd0;
      lb_idx_q     <= 4'd0;
      lb_data_q    <= 32'd0;
      lb_bank_q    <= 1'b0;
      line_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      txt_q        <= txt_d;
      layer_q      <= layer_d;
      word_q       <= word_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      lb_we_q      <= lb_we_d;
      lb_layer_q   <= lb_layer_d;
      lb_idx_q     <= lb_idx_d;
      lb_data_q    <= lb_data_d;
      lb_bank_q    <= lb_bank_d;
      line_ready_q <= line_ready_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    txt_d   = txt_q;
    layer_d = layer_q;
    word_d  = word_q;
    wr_s    = 1'b0;
    miss_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_s) begin
          en_d    = layer_en;
          p1_d    = p1_base;
          p2_d    = p2_base;
          txt_d   = txt_base;
          word_d  = 4'd0;
          layer_d = first_s[1:0];
          state_d = first_s[2] ? S_REQ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // A grant in the deadline cycle leaves a read in flight, so it must be drained.
        if (deadline_s) begin
          miss_s  = 1'b1;
          state_d = mem_gnt ? S_DRAIN : S_IDLE;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          wr_s = 1'b1;
          if (word_q == LAST_WORD) begin
            word_d  = 4'd0;
            layer_d = next_s[1:0];
            state_d = next_s[2] ? S_REQ : S_DONE;
          end else begin
            word_d  = word_q + 4'd1;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
        // Data landing in the deadline cycle is kept, but the line still counts as missed.
        if (deadline_s) begin
          miss_s  = 1'b1;
          state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        end else begin
          miss_s  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: state_d = mem_rvalid ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d = (state_d == S_REQ);
    case (layer_d)
      2'd0:    base_sel_s = p1_d;
      2'd1:    base_sel_s = p2_d;
      default: base_sel_s = txt_d;
    endcase
    if (mem_req_d) begin
      mem_addr_d = base_sel_s + ADDR_W'(word_d);
    end else begin
      mem_addr_d = {ADDR_W{1'b0}};
    end
    lb_we_d = wr_s;
    if (wr_s) begin
      lb_layer_d = layer_q;
      lb_idx_d   = word_q;
      lb_data_d  = mem_rdata;
    end else begin
      lb_layer_d = lb_layer_q;
      lb_idx_d   = lb_idx_q;
      lb_data_d  = lb_data_q;
    end
    line_ready_d = (state_q == S_DONE);
    lb_bank_d    = (state_q == S_DONE) ? ~lb_bank_q : lb_bank_q;
    if (miss_s) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign lb_we      = lb_we_q;
  assign lb_layer   = lb_layer_q;
  assign lb_idx     = lb_idx_q;
  assign lb_data    = lb_data_q;
  assign lb_bank    = lb_bank_q;
  assign line_ready = line_ready_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_t03_layer_fetch_sched.sv
// Self-checking bench for t03_layer_fetch_sched: vector table, directed corner sequences,
// and randomized lines checked against a list-based fetch model.
module tb_t03_layer_fetch_sched;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [10:0] Hcnt, Vcnt;
  logic [2:0]  layer_en;
  logic [11:0] p1_base, p2_base, txt_base;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        lb_we, lb_bank, line_ready, underrun, underrun_clr;
  logic [1:0]  lb_layer;
  logic [3:0]  lb_idx;
  logic [31:0] lb_data;

  t03_layer_fetch_sched dut (
    .clk(clk), .nrst(nrst), .Hcnt(Hcnt), .Vcnt(Vcnt), .layer_en(layer_en),
    .p1_base(p1_base), .p2_base(p2_base), .txt_base(txt_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_layer(lb_layer), .lb_idx(lb_idx), .lb_data(lb_data),
    .lb_bank(lb_bank), .line_ready(line_ready), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] layer; logic [3:0] idx; logic [31:0] data; } got_t;
  typedef struct packed { logic [1:0] layer; logic [3:0] idx; logic [11:0] addr; } exp_t;
  typedef struct {
    logic [2:0]  en;
    logic [11:0] b1, b2, b3;
    logic [10:0] vc;
    int          n_wr;
    logic [11:0] a_first, a_last;
    int          n_rdy;
  } vec_t;

  got_t        got_q[$];
  exp_t        exp_q[$];
  logic [11:0] gnt_addrs[$];
  vec_t        vt[8];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, trig_cyc = 0, first_req = -1, ready_cyc = -1;
  int ready_cnt = 0, req_cycles = 0;
  int rv_cnt = 0, req_age = 0, gnt_lat = 0, rv_dly = 1;
  logic        gnt_block = 1'b0;
  logic        bank_exp = 1'b0;
  logic [11:0] pend_addr = 12'h000;

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return {8'h5A, a ^ 12'hA5C, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: layers in P1,P2,TEXT order, WORDS consecutive addresses each, mod 4096.
  function automatic void build_exp(input logic [2:0] en, input logic [11:0] b1, b2, b3);
    logic [11:0] base [3];
    exp_t e;
    base[0] = b1; base[1] = b2; base[2] = b3;
    exp_q.delete();
    for (int l = 0; l < 3; l++) begin
      if (en[l]) begin
        for (int w = 0; w < WORDS; w++) begin
          e.layer = 2'(l); e.idx = 4'(w); e.addr = 12'(base[l] + 12'(w));
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  function automatic logic writes_ok();
    if (got_q.size() != exp_q.size() || gnt_addrs.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) begin
      if (got_q[i].layer != exp_q[i].layer || got_q[i].idx != exp_q[i].idx ||
          got_q[i].data != data_of(exp_q[i].addr) || gnt_addrs[i] != exp_q[i].addr)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clear_mon();
    got_q.delete(); gnt_addrs.delete();
    ready_cnt = 0; req_cycles = 0; first_req = -1; ready_cyc = -1; req_age = 0;
  endtask

  // One cycle: sample outputs at negedge, then drive the memory responder for this cycle.
  task automatic tick();
    got_t g;
    @(negedge clk);
    cyc++;
    if (lb_we) begin
      g.layer = lb_layer; g.idx = lb_idx; g.data = lb_data;
      got_q.push_back(g);
    end
    if (line_ready) begin
      ready_cnt++;
      if (ready_cyc < 0) ready_cyc = cyc;
    end
    if (mem_req) begin
      req_cycles++;
      if (first_req < 0) first_req = cyc;
    end
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data_of(pend_addr);
      end
    end
    mem_gnt = 1'b0;
    if (mem_req && !gnt_block) begin
      if (req_age >= gnt_lat) begin
        mem_gnt = 1'b1; pend_addr = mem_addr; rv_cnt = rv_dly; req_age = 0;
        gnt_addrs.push_back(mem_addr);
      end else begin
        req_age++;
      end
    end
  endtask

  task automatic run_line(input int n);
    clear_mon();
    tick(); Hcnt = 11'd600; trig_cyc = cyc;
    for (int i = 1; i <= n; i++) begin tick(); Hcnt = 11'(600 + i); end
    tick(); Hcnt = 11'd0;
  endtask

  task automatic check_full_line(input string tag);
    build_exp(layer_en, p1_base, p2_base, txt_base);
    run_line(120);
    bank_exp = ~bank_exp;
    check({tag, "_order"}, 32'(writes_ok()), 32'd1);
    check({tag, "_ready"}, 32'(ready_cnt), 32'd1);
    check({tag, "_bank"}, 32'(lb_bank), 32'(bank_exp));
  endtask

  initial begin
    nrst = 1'b0; Hcnt = 11'd0; Vcnt = 11'd100; layer_en = 3'b000;
    p1_base = 12'h000; p2_base = 12'h000; txt_base = 12'h000;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; underrun_clr = 1'b0;

    vt[0] = '{3'b111, 12'h100, 12'h200, 12'h300, 11'd100, 12, 12'h100, 12'h303, 1};
    vt[1] = '{3'b100, 12'h100, 12'h200, 12'h300, 11'd100, 4,  12'h300, 12'h303, 1};
    vt[2] = '{3'b000, 12'h100, 12'h200, 12'h300, 11'd50,  0,  12'h000, 12'h000, 1};
    vt[3] = '{3'b111, 12'h100, 12'h200, 12'h300, 11'd28,  0,  12'h000, 12'h000, 0};
    vt[4] = '{3'b111, 12'h100, 12'h200, 12'h300, 11'd799, 0,  12'h000, 12'h000, 0};
    vt[5] = '{3'b001, 12'hFFE, 12'h200, 12'h300, 11'd29,  4,  12'hFFE, 12'h001, 1};
    vt[6] = '{3'b010, 12'h100, 12'hABC, 12'h300, 11'd798, 4,  12'hABC, 12'hABF, 1};
    vt[7] = '{3'b101, 12'h010, 12'h200, 12'h7F0, 11'd400, 8,  12'h010, 12'h7F3, 1};

    tick(); tick();
    check("reset_ctrl", 32'({mem_req, mem_addr, lb_we, lb_layer, lb_idx, lb_bank, line_ready, underrun}), 32'd0);
    check("reset_data", lb_data, 32'd0);
    nrst = 1'b1;
    tick(); tick();
    check("post_reset_ctrl", 32'({mem_req, lb_we, lb_bank, line_ready, underrun}), 32'd0);

    // Table-driven lines with immediate grant and rvalid one cycle later.
    gnt_lat = 0; rv_dly = 1;
    for (int i = 0; i < 8; i++) begin
      layer_en = vt[i].en; p1_base = vt[i].b1; p2_base = vt[i].b2; txt_base = vt[i].b3;
      Vcnt = vt[i].vc;
      build_exp(vt[i].en, vt[i].b1, vt[i].b2, vt[i].b3);
      run_line(120);
      if (vt[i].n_rdy == 1) bank_exp = ~bank_exp;
      check($sformatf("vec%0d_nwr", i), 32'(got_q.size()), 32'(vt[i].n_wr));
      check($sformatf("vec%0d_ready", i), 32'(ready_cnt), 32'(vt[i].n_rdy));
      check($sformatf("vec%0d_bank", i), 32'(lb_bank), 32'(bank_exp));
      if (vt[i].n_wr > 0) begin
        check($sformatf("vec%0d_first", i), (gnt_addrs.size() > 0) ? 32'(gnt_addrs[0]) : 32'hDEAD, 32'(vt[i].a_first));
        check($sformatf("vec%0d_last", i), (gnt_addrs.size() > 0) ? 32'(gnt_addrs[$]) : 32'hDEAD, 32'(vt[i].a_last));
        check($sformatf("vec%0d_req_lat", i), 32'(first_req - trig_cyc), 32'd1);
      end
      if (vt[i].n_rdy == 1) check($sformatf("vec%0d_order", i), 32'(writes_ok()), 32'd1);
      if (vt[i].en == 3'b000 && vt[i].n_rdy == 1) begin
        check("noen_ready_lat", 32'(ready_cyc - trig_cyc), 32'd2);
        check("noen_no_req", 32'(req_cycles), 32'd0);
      end
    end

    // Second Hcnt==600 while busy must be ignored.
    layer_en = 3'b111; p1_base = 12'h100; p2_base = 12'h200; txt_base = 12'h300; Vcnt = 11'd200;
    build_exp(layer_en, p1_base, p2_base, txt_base);
    clear_mon();
    tick(); Hcnt = 11'd600;
    tick(); Hcnt = 11'd601;
    tick(); Hcnt = 11'd600;
    for (int i = 3; i <= 100; i++) begin tick(); Hcnt = 11'(600 + i); end
    tick(); Hcnt = 11'd0;
    bank_exp = ~bank_exp;
    check("retrig_order", 32'(writes_ok()), 32'd1);
    check("retrig_ready", 32'(ready_cnt), 32'd1);
    check("retrig_bank", 32'(lb_bank), 32'(bank_exp));

    // Grant withheld until the deadline.
    gnt_block = 1'b1;
    clear_mon();
    tick(); Hcnt = 11'd600;
    for (int i = 1; i <= 195; i++) begin tick(); Hcnt = 11'(600 + i); end
    tick(); Hcnt = 11'd0;
    tick(); tick();
    gnt_block = 1'b0;
    check("nognt_req_cycles", 32'(req_cycles), 32'd190);
    check("nognt_req_low", 32'(mem_req), 32'd0);
    check("nognt_underrun", 32'(underrun), 32'd1);
    check("nognt_ready", 32'(ready_cnt), 32'd0);
    check("nognt_bank", 32'(lb_bank), 32'(bank_exp));
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0; tick();
    check("underrun_clr", 32'(underrun), 32'd0);

    // Deadline while waiting for read data; rvalid arrives three cycles later.
    gnt_lat = 0; rv_dly = 4;
    clear_mon();
    tick(); Hcnt = 11'd600;
    tick(); Hcnt = 11'd700;
    tick(); Hcnt = 11'd790;
    for (int i = 0; i < 8; i++) begin tick(); Hcnt = 11'(791 + i); end
    tick(); Hcnt = 11'd0;
    check("dlwait_no_we", 32'(got_q.size()), 32'd0);
    check("dlwait_underrun", 32'(underrun), 32'd1);
    check("dlwait_ready", 32'(ready_cnt), 32'd0);
    check("dlwait_req_cycles", 32'(req_cycles), 32'd1);
    check("dlwait_bank", 32'(lb_bank), 32'(bank_exp));
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    rv_dly = 1;
    check_full_line("after_dlwait");

    // Grant lands in the deadline cycle: still drains.
    gnt_lat = 1; rv_dly = 2;
    clear_mon();
    tick(); Hcnt = 11'd600;
    tick(); Hcnt = 11'd700;
    tick(); Hcnt = 11'd790;
    for (int i = 0; i < 8; i++) begin tick(); Hcnt = 11'(791 + i); end
    tick(); Hcnt = 11'd0;
    check("dlgnt_no_we", 32'(got_q.size()), 32'd0);
    check("dlgnt_underrun", 32'(underrun), 32'd1);
    check("dlgnt_ready", 32'(ready_cnt), 32'd0);
    check("dlgnt_req_cycles", 32'(req_cycles), 32'd2);
    check("dlgnt_req_low", 32'(mem_req), 32'd0);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    gnt_lat = 0; rv_dly = 1;
    check_full_line("after_dlgnt");

    // Randomized lines against the reference model.
    for (int r = 0; r < 20; r++) begin
      layer_en = 3'($urandom_range(0, 7));
      p1_base = 12'($urandom); p2_base = 12'($urandom); txt_base = 12'($urandom);
      Vcnt = 11'($urandom_range(29, 798));
      gnt_lat = $urandom_range(0, 2); rv_dly = $urandom_range(1, 3);
      check_full_line($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_underrun", r), 32'(underrun), 32'd0);
    end

    // Asynchronous reset in the middle of a read.
    gnt_lat = 0; rv_dly = 3; layer_en = 3'b111; Vcnt = 11'd300;
    clear_mon();
    tick(); Hcnt = 11'd600;
    tick(); Hcnt = 11'd601;
    tick(); Hcnt = 11'd602;
    #2 nrst = 1'b0;
    #1;
    check("arst_ctrl", 32'({mem_req, mem_addr, lb_we, lb_layer, lb_idx, lb_bank, line_ready, underrun}), 32'd0);
    check("arst_data", lb_data, 32'd0);
    rv_cnt = 0; mem_rvalid = 1'b0; mem_gnt = 1'b0; req_age = 0; bank_exp = 1'b0;
    tick(); Hcnt = 11'd0;
    tick(); nrst = 1'b1;
    tick();
    rv_dly = 1;
    check_full_line("post_arst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
